// File: rtl/writeback_stage.sv
// RV32I writeback stage: two register stages feeding the register file write port,
// load alignment/extension, load fault detection, forwarding/hazard info and retire counter.
`timescale 1ns/1ps

module writeback_stage #(
  parameter int unsigned RETIRE_WIDTH    = 32,
  parameter int unsigned TRAP_MISALIGNED = 1
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic                    i_Valid,
  input  logic [4:0]              i_RegDest,
  input  logic [1:0]              i_ResultSel,
  input  logic [2:0]              i_Funct3,
  input  logic [31:0]             i_AluResult,
  input  logic [31:0]             i_PcPlus4,
  input  logic [31:0]             i_LoadData,
  output logic                    o_WriteEnable,
  output logic [4:0]              o_RegDest,
  output logic [31:0]             o_DataOut,
  output logic                    o_FwdValid,
  output logic [4:0]              o_FwdReg,
  output logic [31:0]             o_FwdData,
  output logic                    o_LoadPending,
  output logic [4:0]              o_LoadPendingReg,
  output logic                    o_LoadFault,
  output logic [RETIRE_WIDTH-1:0] o_RetireCount
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC   = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // S1 state
  logic              s1_valid_q;
  logic [REG_W-1:0]  s1_rd_q;
  logic [1:0]        s1_sel_q;
  logic [2:0]        s1_funct3_q;
  logic [1:0]        s1_addr_q;
  logic [XLEN-1:0]   s1_value_q;

  // S2 / output state
  logic                    wen_q;
  logic [REG_W-1:0]        rd_q;
  logic [XLEN-1:0]         data_q;
  logic                    fault_q;
  logic [RETIRE_WIDTH-1:0] retire_q;

  // S1 -> S2 combinational results
  logic            is_load_c;
  logic            misalign_c;
  logic            illegal_c;
  logic            fault_d;
  logic            wen_d;
  logic            retire_d;
  logic [XLEN-1:0] load_shift_c;
  logic [15:0]     load_half_c;
  logic [XLEN-1:0] load_val_c;
  logic [XLEN-1:0] data_d;

  // S1 capture: payload only loads on accept, so the forwarding view stays stable while idle
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      s1_valid_q  <= 1'b0;
      s1_rd_q     <= '0;
      s1_sel_q    <= '0;
      s1_funct3_q <= '0;
      s1_addr_q   <= '0;
      s1_value_q  <= '0;
    end else begin
      s1_valid_q <= i_Valid;
      if (i_Valid) begin
        s1_rd_q     <= i_RegDest;
        s1_sel_q    <= i_ResultSel;
        s1_funct3_q <= i_Funct3;
        s1_addr_q   <= i_AluResult[1:0];
        s1_value_q  <= (i_ResultSel == SEL_PC) ? i_PcPlus4 : i_AluResult;
      end
    end
  end

  // Load alignment, fault detection and S2 next-state
  always_comb begin
    is_load_c    = 1'b0;
    misalign_c   = 1'b0;
    illegal_c    = 1'b0;
    fault_d      = 1'b0;
    wen_d        = 1'b0;
    retire_d     = 1'b0;
    load_shift_c = i_LoadData >> {s1_addr_q, 3'b000};
    load_half_c  = s1_addr_q[1] ? i_LoadData[31:16] : i_LoadData[15:0];
    load_val_c   = i_LoadData;
    data_d       = s1_value_q;

    is_load_c = (s1_sel_q == SEL_LOAD);

    case (s1_funct3_q)
      F3_LB:   load_val_c = {{24{load_shift_c[7]}}, load_shift_c[7:0]};
      F3_LBU:  load_val_c = {24'h000000, load_shift_c[7:0]};
      F3_LH:   begin
        load_val_c = {{16{load_half_c[15]}}, load_half_c};
        misalign_c = s1_addr_q[0];
      end
      F3_LHU:  begin
        load_val_c = {16'h0000, load_half_c};
        misalign_c = s1_addr_q[0];
      end
      F3_LW:   begin
        load_val_c = i_LoadData;
        misalign_c = (s1_addr_q != 2'b00);
      end
      default: begin
        load_val_c = i_LoadData;
        illegal_c  = 1'b1;
      end
    endcase

    fault_d  = s1_valid_q && is_load_c && (TRAP_MISALIGNED != 0) && (misalign_c || illegal_c);
    wen_d    = s1_valid_q && (s1_rd_q != '0) && !fault_d;
    retire_d = s1_valid_q && !fault_d;
    data_d   = is_load_c ? load_val_c : s1_value_q;
  end

  // S2 capture; the retire count updates on the same edge the write becomes visible
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wen_q    <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      retire_q <= '0;
    end else begin
      wen_q   <= wen_d;
      fault_q <= fault_d;
      if (wen_d) begin
        rd_q   <= s1_rd_q;
        data_q <= data_d;
      end
      if (retire_d) begin
        retire_q <= retire_q + RETIRE_WIDTH'(1);
      end
    end
  end

  assign o_WriteEnable    = wen_q;
  assign o_RegDest        = rd_q;
  assign o_DataOut        = data_q;
  assign o_LoadFault      = fault_q;
  assign o_RetireCount    = retire_q;

  assign o_FwdValid       = s1_valid_q && !is_load_c && (s1_rd_q != '0);
  assign o_FwdReg         = s1_rd_q;
  assign o_FwdData        = s1_value_q;
  assign o_LoadPending    = s1_valid_q && is_load_c && (s1_rd_q != '0);
  assign o_LoadPendingReg = s1_rd_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a default instance plus a 4-bit retire counter
// instance sharing the same stimulus, checked with immediate assertions.
`timescale 1ns/1ps

module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [4:0]  rd;
  logic [1:0]  sel;
  logic [2:0]  f3;
  logic [31:0] alu;
  logic [31:0] pc4;
  logic [31:0] ldata;

  logic        we, fwd_v, lp, fault;
  logic [4:0]  rdo, fwd_r, lp_r;
  logic [31:0] dout, fwd_d, rc;

  logic        we4, fwd_v4, lp4, fault4;
  logic [4:0]  rdo4, fwd_r4, lp_r4;
  logic [31:0] dout4, fwd_d4;
  logic [3:0]  rc4;

  int n_cmp;
  int n_err;

  writeback_stage dut (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_RegDest(rd), .i_ResultSel(sel),
    .i_Funct3(f3), .i_AluResult(alu), .i_PcPlus4(pc4), .i_LoadData(ldata),
    .o_WriteEnable(we), .o_RegDest(rdo), .o_DataOut(dout), .o_FwdValid(fwd_v),
    .o_FwdReg(fwd_r), .o_FwdData(fwd_d), .o_LoadPending(lp), .o_LoadPendingReg(lp_r),
    .o_LoadFault(fault), .o_RetireCount(rc)
  );

  writeback_stage #(.RETIRE_WIDTH(4)) dut4 (
    .i_Clock(clk), .i_Reset(rst), .i_Valid(valid), .i_RegDest(rd), .i_ResultSel(sel),
    .i_Funct3(f3), .i_AluResult(alu), .i_PcPlus4(pc4), .i_LoadData(ldata),
    .o_WriteEnable(we4), .o_RegDest(rdo4), .o_DataOut(dout4), .o_FwdValid(fwd_v4),
    .o_FwdReg(fwd_r4), .o_FwdData(fwd_d4), .o_LoadPending(lp4), .o_LoadPendingReg(lp_r4),
    .o_LoadFault(fault4), .o_RetireCount(rc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] r, input logic [1:0] s, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] p);
    valid = 1'b1; rd = r; sel = s; f3 = f; alu = a; pc4 = p;
  endtask

  task automatic idle();
    valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; valid = 1'b0; rd = '0; sel = '0; f3 = '0; alu = '0; pc4 = '0; ldata = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_we", 32'(we), 0);
    check("rst_regdest", 32'(rdo), 0);
    check("rst_dataout", dout, 0);
    check("rst_fwdvalid", 32'(fwd_v), 0);
    check("rst_loadpending", 32'(lp), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_retire", rc, 0);
    check("rst_retire4", 32'(rc4), 0);

    // ALU op
    issue(5, 0, 0, 32'h1234, 0); tick();
    check("alu_fwdvalid", 32'(fwd_v), 1);
    check("alu_fwdreg", 32'(fwd_r), 5);
    check("alu_fwddata", fwd_d, 32'h1234);
    check("alu_we_early", 32'(we), 0);
    idle(); tick();
    check("alu_we", 32'(we), 1);
    check("alu_regdest", 32'(rdo), 5);
    check("alu_dataout", dout, 32'h1234);
    check("alu_retire", rc, 1);
    check("alu_fwd_gone", 32'(fwd_v), 0);
    tick();
    check("alu_we_pulse", 32'(we), 0);

    // LB sign-extension
    issue(7, 1, 0, 32'h103, 0); tick();
    check("lb_pending", 32'(lp), 1);
    check("lb_pendreg", 32'(lp_r), 7);
    check("lb_fwdvalid", 32'(fwd_v), 0);
    ldata = 32'h80FF_0000; idle(); tick();
    check("lb_we", 32'(we), 1);
    check("lb_data", dout, 32'hFFFF_FF80);
    check("lb_fault", 32'(fault), 0);
    check("lb_retire", rc, 2);

    // LBU
    issue(7, 1, 4, 32'h103, 0); tick();
    idle(); tick();
    check("lbu_data", dout, 32'h0000_0080);
    check("lbu_retire", rc, 3);

    // LHU upper half
    issue(7, 1, 5, 32'h102, 0); tick();
    idle(); tick();
    check("lhu_data", dout, 32'h0000_80FF);
    check("lhu_retire", rc, 4);

    // Misaligned LW
    issue(3, 1, 2, 32'h101, 0); tick();
    check("lwmis_pending", 32'(lp), 1);
    ldata = 32'h1234_5678; idle(); tick();
    check("lwmis_fault", 32'(fault), 1);
    check("lwmis_we", 32'(we), 0);
    check("lwmis_regdest_hold", 32'(rdo), 7);
    check("lwmis_data_hold", dout, 32'h0000_80FF);
    check("lwmis_retire", rc, 4);
    tick();
    check("lwmis_fault_pulse", 32'(fault), 0);

    // Illegal funct3 = 7
    issue(3, 1, 7, 32'h101, 0); tick();
    idle(); tick();
    check("f3_7_fault", 32'(fault), 1);
    check("f3_7_we", 32'(we), 0);
    check("f3_7_retire", rc, 4);

    // Misaligned LH
    issue(3, 1, 1, 32'h101, 0); tick();
    idle(); tick();
    check("lhmis_fault", 32'(fault), 1);
    check("lhmis_retire", rc, 4);

    // Aligned LW
    issue(9, 1, 2, 32'h100, 0); tick();
    ldata = 32'hDEAD_BEEF; idle(); tick();
    check("lw_fault", 32'(fault), 0);
    check("lw_regdest", 32'(rdo), 9);
    check("lw_data", dout, 32'hDEAD_BEEF);
    check("lw_retire", rc, 5);

    // LH sign-extension, lower half
    issue(10, 1, 1, 32'h100, 0); tick();
    ldata = 32'h0000_8001; idle(); tick();
    check("lh_data", dout, 32'hFFFF_8001);
    check("lh_retire", rc, 6);

    // rd = 0 link write: retires, no write
    issue(0, 2, 0, 32'h999, 32'h40); tick();
    check("rd0_fwdvalid", 32'(fwd_v), 0);
    check("rd0_pending", 32'(lp), 0);
    idle(); tick();
    check("rd0_we", 32'(we), 0);
    check("rd0_retire", rc, 7);

    // PC+4 link write
    issue(4, 2, 0, 32'h999, 32'h44); tick();
    check("pc4_fwddata", fwd_d, 32'h44);
    idle(); tick();
    check("pc4_data", dout, 32'h44);
    check("pc4_retire", rc, 8);

    // sel = 3 acts as ALU
    issue(6, 3, 0, 32'h55, 32'h77); tick();
    check("sel3_fwdvalid", 32'(fwd_v), 1);
    idle(); tick();
    check("sel3_data", dout, 32'h55);
    check("sel3_retire", rc, 9);

    // Back-to-back stream to rd = 1
    issue(1, 0, 0, 1, 0); tick();
    issue(1, 0, 0, 2, 0); tick();
    check("b2b_we1", 32'(we), 1);
    check("b2b_data1", dout, 1);
    check("b2b_retire1", rc, 10);
    issue(1, 0, 0, 3, 0); tick();
    check("b2b_we2", 32'(we), 1);
    check("b2b_data2", dout, 2);
    issue(1, 0, 0, 4, 0); tick();
    check("b2b_we3", 32'(we), 1);
    check("b2b_data3", dout, 3);
    idle(); tick();
    check("b2b_we4", 32'(we), 1);
    check("b2b_data4", dout, 4);
    check("b2b_retire4", rc, 13);
    check("b2b_retire_w4", 32'(rc4), 13);
    tick();
    check("b2b_idle_we", 32'(we), 0);
    check("b2b_idle_hold", dout, 4);

    // Reset while a load is in flight
    issue(8, 1, 2, 32'h100, 0); tick();
    check("rstfl_pending", 32'(lp), 1);
    ldata = 32'hCAFE_F00D; rst = 1'b1; issue(5, 0, 0, 32'h77, 0); tick();
    check("rstfl_we", 32'(we), 0);
    check("rstfl_fault", 32'(fault), 0);
    check("rstfl_regdest", 32'(rdo), 0);
    check("rstfl_data", dout, 0);
    check("rstfl_retire", rc, 0);
    check("rstfl_fwdvalid", 32'(fwd_v), 0);
    check("rstfl_pending_clr", 32'(lp), 0);
    check("rstfl_fwdreg", 32'(fwd_r), 0);
    rst = 1'b0; idle(); tick();
    check("rstfl_after_fwd", 32'(fwd_v), 0);
    tick();
    check("rstfl_after_we", 32'(we), 0);
    check("rstfl_after_retire", rc, 0);

    // 17 retirements: the 4-bit counter wraps to 1
    for (int k = 1; k <= 17; k++) begin
      issue(1, 0, 0, 32'(k), 0); tick();
      if (k == 17) begin
        check("wrap16_retire", rc, 16);
        check("wrap16_retire_w4", 32'(rc4), 0);
      end
    end
    idle(); tick();
    check("wrap_data", dout, 17);
    check("wrap_retire", rc, 17);
    check("wrap_retire_w4", 32'(rc4), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage of the RV32I core. Sits directly upstream of the register file and drives its write enable, destination index and write data.
- Takes the completed result from execute: ALU result, PC+4 for JAL/JALR, or a load.
- For loads, captures the raw word from the synchronous data memory one cycle after issue, then aligns and sign/zero-extends it.
- Also provides forwarding/hazard information to decode and maintains the retired-instruction counter.

Parameters:
- RETIRE_WIDTH, 32: width of the retired-instruction counter; wraps modulo 2^RETIRE_WIDTH.
- TRAP_MISALIGNED, 1: 1 = misaligned/illegal loads suppress the write and pulse o_LoadFault; 0 = the address low bits are ignored for alignment checking.

Ports:
- i_Clock  in  1  single core clock; all state updates on posedge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Valid  in  1  execute presents a completing instruction this cycle.
- i_RegDest  in  5  rd index.
- i_ResultSel  in  2  0 = ALU, 1 = load, 2 = PC+4, 3 = treated as ALU.
- i_Funct3  in  3  load width/sign (0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU).
- i_AluResult  in  32  ALU result; for loads this is the byte address.
- i_PcPlus4  in  32  link value.
- i_LoadData  in  32  raw aligned word from data memory; valid in the cycle after the load is accepted.
- o_WriteEnable  out  1  register file write strobe.
- o_RegDest  out  5  register file write index.
- o_DataOut  out  32  register file write data.
- o_FwdValid  out  1  S1 holds a non-load result with rd != 0.
- o_FwdReg  out  5  S1 rd.
- o_FwdData  out  32  S1 result.
- o_LoadPending  out  1  S1 holds a load with rd != 0 (decode must stall on a match).
- o_LoadPendingReg  out  5  rd of that load.
- o_LoadFault  out  1  one-cycle pulse for a faulting load.
- o_RetireCount  out  RETIRE_WIDTH  count of retired instructions.

Behaviour:
- Pipeline structure
  - Two register stages, S1 and S2. No backpressure: every i_Valid cycle is accepted unconditionally.
  - S1 captures valid, rd, sel, funct3, addr[1:0] and the pre-muxed value (AluResult or PcPlus4) at the accept edge.
  - S2 captures the final write data, write enable and fault flag at the following edge.
- Latency
  - Accept at edge N; o_WriteEnable is high for exactly the cycle after edge N+1.
  - Throughput is one instruction per cycle.
- Write enable: o_WriteEnable = S2.valid & (rd != 0) & !fault. When it is low, o_RegDest and o_DataOut hold their last values.
- Load alignment (computed between S1 and S2 from i_LoadData and S1.addr):
  - LB/LBU: byte (i_LoadData >> 8*addr[1:0])[7:0], sign- or zero-extended.
  - LH/LHU: halfword at addr[1]*16, sign- or zero-extended.
  - LW: the full word.
- Load faults (TRAP_MISALIGNED = 1)
  - Fault conditions: LH/LHU with addr[0] = 1; LW with addr[1:0] != 0; funct3 in {3, 6, 7}.
  - Effect: no write, o_LoadFault high in the S2 cycle, and the instruction does not retire.
- Retire counter
  - o_RetireCount increments by 1 on each S2.valid & !fault, including rd = 0 instructions (NOPs retire).
  - Wraps from all-ones to 0.
- Forwarding
  - o_FwdValid/o_FwdReg/o_FwdData are combinational from S1.
  - o_FwdValid = 0 for loads and for rd = 0.
  - Decode forwards S2 values from o_WriteEnable/o_RegDest/o_DataOut itself.
- Load-use hazard: o_LoadPending = S1.valid & sel == 1 & rd != 0.
- Back-to-back and simultaneous events
  - Back-to-back instructions to the same rd: both write in order; the later value wins.
  - Register file write and read of the same register in one cycle is the register file's concern, not this stage's.
- Reset
  - Clears S1.valid, S2.valid, o_WriteEnable, o_FwdValid, o_LoadPending, o_LoadFault and o_RetireCount to 0.
  - o_RegDest, o_DataOut, o_FwdReg, o_FwdData and o_LoadPendingReg reset to 0.
  - Reset asserted mid-flight drops in-flight instructions with no write and no retire.
  - i_Valid during a reset cycle is ignored.

Test Plan:
- ALU op: i_Valid = 1, rd = 5, sel = 0, AluResult = 0x1234 -> o_FwdValid = 1/FwdReg = 5 next cycle; o_WriteEnable = 1, RegDest = 5, DataOut = 0x1234 the cycle after; RetireCount = 1.
- LB sign-extension: rd = 7, sel = 1, funct3 = 0, addr = 0x103, LoadData = 0x80FF_0000 -> o_LoadPending = 1/Reg = 7, then write 0xFFFF_FF80. Repeat with LBU -> 0x0000_0080. LHU at addr 0x102 -> 0x0000_80FF.
- Misaligned LW: addr = 0x101, rd = 3 -> o_LoadFault pulse, o_WriteEnable = 0, RetireCount unchanged. Same stimulus with funct3 = 7 -> fault.
- rd = 0 with sel = 2, PcPlus4 = 0x40 -> no write, o_FwdValid = 0, RetireCount increments.
- Back-to-back stream: 4 consecutive ALU ops to rd = 1 with values 1..4 -> four consecutive write cycles with data 1, 2, 3, 4; RetireCount = 4.
- Reset and wrap:
  - Assert i_Reset the cycle after accepting a load -> no write, no fault, all outputs 0.
  - With RETIRE_WIDTH = 4, 17 retirements -> RetireCount = 1.
